// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 4-bit CPU control path.
// Contents:
//   - datapath widths (data, PC, instruction, register address);
//   - instruction field bit positions and a packed instruction view;
//   - opcode constants;
//   - FSM state encoding for the sequencer.
package cpu_pkg;

  localparam int DATA_W  = 4;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 12;
  localparam int NREGS   = 4;
  localparam int RADDR_W = 2;

  // Instruction field positions: op = [11:8], rd = [7:6], rs = [5:4], imm = [3:0]
  localparam int OP_HI  = 11;
  localparam int OP_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RS_HI  = 5;
  localparam int RS_LO  = 4;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  typedef struct packed {
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic [DATA_W-1:0]  imm;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] word);
    instr_t d;
    d.op  = word[OP_HI:OP_LO];
    d.rd  = word[RD_HI:RD_LO];
    d.rs  = word[RS_HI:RS_LO];
    d.imm = word[IMM_HI:IMM_LO];
    return d;
  endfunction

  // Opcodes 0x0..0x6 go through the ALU and update R[rd] and Z.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file
// 4 x 4-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-low reset clearing every register to 0.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   we, waddr, wdata    write port (takes effect at the rising edge)
//   raddr_a / rdata_a   read port A (combinational)
//   raddr_b / rdata_b   read port B (combinational)
//   r0                  direct view of R[0]
module reg_file
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0]  rdata_a,
  input  logic [RADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]  rdata_b,
  output logic [DATA_W-1:0]  r0
);

  logic [DATA_W-1:0] regs [NREGS];

  // One flop bank per register; each has its own write decode.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q_reg <= '0;
      end else if (we && (waddr == RADDR_W'(gi))) begin
        q_reg <= wdata;
      end
    end

    assign regs[gi] = q_reg;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign r0      = regs[0];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control unit of the 4-bit CPU. Fetches 12-bit instructions
// from a synchronous ROM, decodes them, drives the external ALU and writes
// results back to a 4 x 4-bit register file. Handles LDI, JZ, JMP, NOP, HALT.
// Each non-HALT instruction runs FETCH -> DECODE -> EXEC -> WB (4 cycles);
// HALT runs FETCH -> DECODE and drops into IDLE.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   run                        start/resume request (sampled in IDLE only)
//   imemAddr / imemData        ROM address (= pc) / ROM data one cycle later
//   aluA, aluB, aluOpcode      ALU operands and opcode, non-zero only in EXEC
//   aluResult                  combinational ALU result
//   halted                     set by HALT, cleared when run leaves IDLE
//   divErr                     sticky divide-by-zero flag
//   pc, r0                     program counter and R[0], for observation
module alu_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  output logic [DATA_W-1:0]  aluA,
  output logic [DATA_W-1:0]  aluB,
  output logic [3:0]         aluOpcode,
  input  logic [DATA_W-1:0]  aluResult,
  output logic               halted,
  output logic               divErr,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  r0
);

  logic [2:0]        state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PC_W-1:0]   pc_next;
  instr_t            ir_reg;
  logic              z_reg;
  logic              halted_reg;
  logic              div_err_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [3:0]        alu_op_reg;
  logic [DATA_W-1:0] res_reg;
  logic              zres_reg;
  logic              divz_reg;

  instr_t             dec;
  logic [RADDR_W-1:0] rf_raddr_a;
  logic [RADDR_W-1:0] rf_raddr_b;
  logic [DATA_W-1:0]  rf_rdata_a;
  logic [DATA_W-1:0]  rf_rdata_b;
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wdata;

  assign dec = decode(imemData);

  // During DECODE the instruction is still on the ROM bus (ir not yet
  // loaded), so the read ports are addressed straight from imemData so the
  // operands can be registered into aluA/aluB for the whole EXEC cycle.
  assign rf_raddr_a = (state_reg == ST_DECODE) ? dec.rd : ir_reg.rd;
  assign rf_raddr_b = (state_reg == ST_DECODE) ? dec.rs : ir_reg.rs;

  // A DIV by zero suppresses the write-back entirely.
  assign rf_we    = (state_reg == ST_WB) &&
                    ((is_alu_op(ir_reg.op) && !divz_reg) || (ir_reg.op == OP_LDI));
  assign rf_wdata = (ir_reg.op == OP_LDI) ? ir_reg.imm : res_reg;

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (ir_reg.rd),
    .wdata   (rf_wdata),
    .raddr_a (rf_raddr_a),
    .rdata_a (rf_rdata_a),
    .raddr_b (rf_raddr_b),
    .rdata_b (rf_rdata_b),
    .r0      (r0)
  );

  // Program counter update applied in WB. JZ tests the Z flag as it stands
  // before this instruction, which JZ itself never modifies.
  always_comb begin
    pc_next = pc_reg + PC_W'(1);
    if (ir_reg.op == OP_JMP) begin
      pc_next = ir_reg.imm;
    end else if ((ir_reg.op == OP_JZ) && z_reg) begin
      pc_next = ir_reg.imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      z_reg       <= 1'b0;
      halted_reg  <= 1'b0;
      div_err_reg <= 1'b0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_op_reg  <= '0;
      res_reg     <= '0;
      zres_reg    <= 1'b0;
      divz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (run) begin
            state_reg  <= ST_FETCH;
            halted_reg <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_reg <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_reg <= dec;
          if (dec.op == OP_HALT) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= pc_reg + PC_W'(1);
            halted_reg <= 1'b1;
          end else begin
            state_reg  <= ST_EXEC;
            alu_a_reg  <= rf_rdata_a;
            alu_b_reg  <= rf_rdata_b;
            alu_op_reg <= is_alu_op(dec.op) ? dec.op : 4'h0;
          end
        end
        ST_EXEC: begin
          state_reg  <= ST_WB;
          res_reg    <= aluResult;
          zres_reg   <= (aluResult == '0);
          divz_reg   <= (ir_reg.op == OP_DIV) && (alu_b_reg == '0);
          // ALU drive is confined to EXEC.
          alu_a_reg  <= '0;
          alu_b_reg  <= '0;
          alu_op_reg <= '0;
        end
        ST_WB: begin
          state_reg <= ST_FETCH;
          pc_reg    <= pc_next;
          if (is_alu_op(ir_reg.op)) begin
            if (divz_reg) begin
              div_err_reg <= 1'b1;
            end else begin
              z_reg <= zres_reg;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign imemAddr  = pc_reg;
  assign pc        = pc_reg;
  assign aluA      = alu_a_reg;
  assign aluB      = alu_b_reg;
  assign aluOpcode = alu_op_reg;
  assign halted    = halted_reg;
  assign divErr    = div_err_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Directed testbench for alu_sequencer. Provides a synchronous instruction
// ROM and a combinational 4-bit ALU around the DUT, loads small programs and
// checks architectural results against hand-computed values.
// "OR Rx,Rx" is used as a probe instruction: it leaves Rx unchanged and is
// the only opcode-1 instruction in the programs, so aluA during its EXEC
// reveals the register contents.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  imemAddr;
  logic [11:0] imemData;
  logic [3:0]  aluA;
  logic [3:0]  aluB;
  logic [3:0]  aluOpcode;
  logic [3:0]  aluResult;
  logic        halted;
  logic        divErr;
  logic [3:0]  pc;
  logic [3:0]  r0;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .imemAddr  (imemAddr),
    .imemData  (imemData),
    .aluA      (aluA),
    .aluB      (aluB),
    .aluOpcode (aluOpcode),
    .aluResult (aluResult),
    .halted    (halted),
    .divErr    (divErr),
    .pc        (pc),
    .r0        (r0)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM
  logic [11:0] rom [16];
  always @(posedge clk) imemData <= rom[imemAddr];

  // External ALU; divide by zero yields 0
  logic [7:0] prod;
  always_comb begin
    prod = {4'h0, aluA} * {4'h0, aluB};
    case (aluOpcode)
      4'h0:    aluResult = aluA & aluB;
      4'h1:    aluResult = aluA | aluB;
      4'h2:    aluResult = aluA + aluB;
      4'h3:    aluResult = prod[3:0];
      4'h4:    aluResult = (aluB == 4'h0) ? 4'h0 : aluA / aluB;
      4'h5:    aluResult = aluA - aluB;
      4'h6:    aluResult = ~(aluA | aluB);
      default: aluResult = 4'h0;
    endcase
  end

  // Probe capture
  logic [3:0] probe_a = 4'h0;
  int         probe_n = 0;
  always @(negedge clk) begin
    if (aluOpcode == 4'h1) begin
      probe_a = aluA;
      probe_n = probe_n + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'hF00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; run is sampled at the following posedge, and the
  // task returns at the negedge after it (first FETCH cycle).
  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_until_halt(input string tag, output int cycles);
    cycles = 0;
    while (!halted && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, 16'(halted), 16'd1);
  endtask

  int cyc;
  int pn;

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    clear_rom();

    // ---- 1: LDI/LDI/ADD/HALT, then resume through JZ (not taken) ----
    rom[0] = 12'h745;  // LDI R1,5
    rom[1] = 12'h783;  // LDI R2,3
    rom[2] = 12'h260;  // ADD R1,R2
    rom[3] = 12'hF00;  // HALT
    rom[4] = 12'h80C;  // JZ 0xC   (Z=0, falls through)
    rom[5] = 12'h150;  // OR R1,R1 (probe)
    rom[6] = 12'hF00;  // HALT
    do_reset();
    check("rst_pc",      16'(pc),        16'h0);
    check("rst_imemaddr",16'(imemAddr),  16'h0);
    check("rst_halted",  16'(halted),    16'h0);
    check("rst_diverr",  16'(divErr),    16'h0);
    check("rst_alua",    16'(aluA),      16'h0);
    check("rst_alub",    16'(aluB),      16'h0);
    check("rst_aluop",   16'(aluOpcode), 16'h0);
    check("rst_r0",      16'(r0),        16'h0);
    step(3);
    check("idle_pc",     16'(pc),        16'h0);
    pulse_run();
    check("t1_fetch0",   16'(imemAddr),  16'h0);
    run_until_halt("t1_halt", cyc);
    check("t1_cycles",   16'(cyc),       16'd14);
    check("t1_pc",       16'(pc),        16'h4);
    check("t1_idle_alua",16'(aluA),      16'h0);
    pn = probe_n;
    pulse_run();
    check("t1_halt_clr", 16'(halted),    16'h0);
    check("t1_resume",   16'(imemAddr),  16'h4);
    run_until_halt("t1_halt2", cyc);
    check("t1_pc2",      16'(pc),        16'h7);
    check("t1_probes",   16'(probe_n - pn), 16'd1);
    check("t1_r1",       16'(probe_a),   16'h8);

    // ---- 2a: SUB to zero then JZ taken ----
    clear_rom();
    rom[0]  = 12'h743;  // LDI R1,3
    rom[1]  = 12'h783;  // LDI R2,3
    rom[2]  = 12'h560;  // SUB R1,R2
    rom[3]  = 12'h80A;  // JZ 0xA
    rom[4]  = 12'h150;  // probe R1
    rom[5]  = 12'hF00;
    rom[10] = 12'h150;  // probe R1
    rom[11] = 12'hF00;
    do_reset();
    pulse_run();
    run_until_halt("t2a_halt", cyc);
    check("t2a_pc",      16'(pc),        16'hC);
    check("t2a_r1",      16'(probe_a),   16'h0);

    // ---- 2b: SUB non-zero, JZ not taken ----
    rom[1] = 12'h782;   // LDI R2,2
    do_reset();
    pulse_run();
    run_until_halt("t2b_halt", cyc);
    check("t2b_pc",      16'(pc),        16'h6);
    check("t2b_r1",      16'(probe_a),   16'h1);

    // ---- 3: DIV by zero, sticky divErr, MUL afterwards ----
    clear_rom();
    rom[0]  = 12'h747;  // LDI R1,7
    rom[1]  = 12'h780;  // LDI R2,0
    rom[2]  = 12'h150;  // probe R1 -> Z=0
    rom[3]  = 12'h460;  // DIV R1,R2
    rom[4]  = 12'h80F;  // JZ 0xF (Z must still be 0)
    rom[5]  = 12'h150;  // probe R1
    rom[6]  = 12'hF00;
    rom[7]  = 12'h7C2;  // LDI R3,2
    rom[8]  = 12'h370;  // MUL R1,R3
    rom[9]  = 12'h150;  // probe R1
    rom[10] = 12'hF00;
    do_reset();
    check("t3_rst_diverr", 16'(divErr),  16'h0);
    pulse_run();
    run_until_halt("t3_halt", cyc);
    check("t3_pc",       16'(pc),        16'h7);
    check("t3_diverr",   16'(divErr),    16'h1);
    check("t3_r1",       16'(probe_a),   16'h7);
    pulse_run();
    run_until_halt("t3_halt2", cyc);
    check("t3_pc2",      16'(pc),        16'hB);
    check("t3_diverr2",  16'(divErr),    16'h1);
    check("t3_mul",      16'(probe_a),   16'hE);

    // ---- 4: PC wrap via JMP 0xF / NOP ----
    clear_rom();
    rom[0]  = 12'h90F;  // JMP 0xF
    rom[15] = 12'hA00;  // NOP
    do_reset();
    pulse_run();
    step(4);
    check("t4_jmp",      16'(imemAddr),  16'hF);
    step(4);
    check("t4_wrap",     16'(imemAddr),  16'h0);

    // ---- 5: reset during WB of LDI R0,9 ----
    clear_rom();
    rom[0] = 12'h709;   // LDI R0,9
    rom[1] = 12'hF00;
    do_reset();
    pulse_run();
    step(3);            // now in WB
    rst_n = 1'b0;
    run   = 1'b1;
    @(negedge clk);
    check("t5_r0",       16'(r0),        16'h0);
    check("t5_pc",       16'(pc),        16'h0);
    step(1);
    rst_n = 1'b1;
    run   = 1'b0;
    step(6);
    check("t5_idle_pc",  16'(pc),        16'h0);
    check("t5_idle_r0",  16'(r0),        16'h0);
    pulse_run();
    run_until_halt("t5_halt", cyc);
    check("t5_r0_run",   16'(r0),        16'h9);
    check("t5_pc_run",   16'(pc),        16'h2);

    // ---- 6: HALT at address 2 and resume ----
    clear_rom();
    rom[0] = 12'hA00;   // NOP
    rom[1] = 12'hA00;   // NOP
    rom[2] = 12'hF00;   // HALT
    rom[3] = 12'h704;   // LDI R0,4
    rom[4] = 12'hF00;
    do_reset();
    pulse_run();
    run_until_halt("t6_halt", cyc);
    check("t6_cycles",   16'(cyc),       16'd10);
    check("t6_pc",       16'(pc),        16'h3);
    pulse_run();
    check("t6_halt_clr", 16'(halted),    16'h0);
    check("t6_resume",   16'(imemAddr),  16'h3);
    run_until_halt("t6_halt2", cyc);
    check("t6_pc2",      16'(pc),        16'h5);
    check("t6_r0",       16'(r0),        16'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
